// File: rtl/rob_ring.sv
// Reorder buffer: N-wide dispatch, M-wide writeback, K-wide in-order commit.
// Tags are {gen, index}; rollback trims the young end in one cycle.
module rob_ring #(
  parameter int DEPTH  = 64,
  parameter int DISP_W = 2,
  parameter int CDB_W  = 2,
  parameter int CMT_W  = 2,
  parameter int INFO_W = 64,
  parameter int DATA_W = 32,
  parameter int EXC_W  = 8,
  localparam int ID_W  = $clog2(DEPTH),
  localparam int TW    = ID_W + 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush_i,
  input  logic [DISP_W-1:0]              disp_valid_i,
  input  logic [DISP_W-1:0][INFO_W-1:0]  disp_info_i,
  output logic                           disp_ready_o,
  output logic [DISP_W-1:0][TW-1:0]      disp_id_o,
  input  logic [CDB_W-1:0]               cdb_valid_i,
  input  logic [CDB_W-1:0][TW-1:0]       cdb_id_i,
  input  logic [CDB_W-1:0][DATA_W-1:0]   cdb_data_i,
  input  logic [CDB_W-1:0][EXC_W-1:0]    cdb_exc_i,
  input  logic                           rb_valid_i,
  input  logic [TW-1:0]                  rb_id_i,
  output logic [CMT_W-1:0]               commit_valid_o,
  output logic [CMT_W-1:0][INFO_W-1:0]   commit_info_o,
  output logic [CMT_W-1:0][DATA_W-1:0]   commit_data_o,
  output logic [CMT_W-1:0][EXC_W-1:0]    commit_exc_o,
  output logic [CMT_W-1:0][TW-1:0]       commit_id_o,
  input  logic [CMT_W-1:0]               commit_req_i,
  output logic [TW-1:0]                  count_o,
  output logic                           empty_o,
  output logic                           full_o
);

  logic [TW-1:0] head_q, head_d;
  logic [TW-1:0] tail_q, tail_d;
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [DEPTH-1:0] done_q, done_d;
  logic [DEPTH-1:0] gen_q, gen_d;
  logic [DEPTH-1:0][INFO_W-1:0] info_q, info_d;
  logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
  logic [DEPTH-1:0][EXC_W-1:0]  exc_q, exc_d;

  logic [TW-1:0] cnt;
  logic [TW:0]   free;
  logic [TW-1:0] ndisp;
  logic [TW-1:0] ncmt;
  logic [TW-1:0] ndisc;
  logic [TW-1:0] rb_off;
  logic [TW-1:0] dptr;
  logic [ID_W-1:0] widx;
  logic [ID_W-1:0] rel;
  logic [DEPTH-1:0] kill;
  logic [CMT_W-1:0][ID_W-1:0] cidx;
  logic c_ok;

  assign cnt          = head_q - tail_q;
  assign free         = (TW+1)'(DEPTH) - (TW+1)'(cnt);
  assign disp_ready_o = free >= (TW+1)'(DISP_W);
  assign count_o      = cnt;
  assign empty_o      = cnt == '0;
  assign full_o       = cnt == TW'(DEPTH);
  assign ndisc        = head_q - rb_id_i - TW'(1);
  assign rb_off       = rb_id_i - tail_q;

  always_comb begin
    for (int i = 0; i < DISP_W; i++) begin
      disp_id_o[i] = head_q + TW'(i);
    end
  end

  // Commit window: stops at the first not-done or excepting entry
  always_comb begin
    c_ok = 1'b1;
    for (int i = 0; i < CMT_W; i++) begin
      commit_id_o[i]    = tail_q + TW'(i);
      cidx[i]           = commit_id_o[i][ID_W-1:0];
      commit_info_o[i]  = info_q[cidx[i]];
      commit_data_o[i]  = data_q[cidx[i]];
      commit_exc_o[i]   = exc_q[cidx[i]];
      commit_valid_o[i] = c_ok && (cnt > TW'(i)) && done_q[cidx[i]];
      c_ok = commit_valid_o[i] && (commit_exc_o[i] == '0);
    end
  end

  always_comb begin
    rel  = '0;
    kill = '0;
    for (int k = 0; k < DEPTH; k++) begin
      rel = ID_W'(k) - rb_id_i[ID_W-1:0] - ID_W'(1);
      kill[k] = rb_valid_i && ({1'b0, rel} < ndisc);
    end
  end

  always_comb begin
    ndisp = '0;
    for (int i = 0; i < DISP_W; i++) begin
      ndisp = ndisp + TW'(disp_valid_i[i]);
    end
  end

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    busy_d = busy_q;
    done_d = done_q;
    gen_d  = gen_q;
    info_d = info_q;
    data_d = data_q;
    exc_d  = exc_q;
    ncmt   = '0;
    widx   = '0;
    dptr   = '0;
    for (int i = 0; i < CMT_W; i++) begin
      if (commit_valid_o[i] && commit_req_i[i]) begin
        busy_d[cidx[i]] = 1'b0;
        ncmt = ncmt + TW'(1);
      end
    end
    tail_d = tail_q + ncmt;
    // Later lanes overwrite earlier ones on a shared tag
    for (int j = 0; j < CDB_W; j++) begin
      widx = cdb_id_i[j][ID_W-1:0];
      if (cdb_valid_i[j] && busy_q[widx] && !done_q[widx] &&
          gen_q[widx] == cdb_id_i[j][ID_W]) begin
        done_d[widx] = 1'b1;
        data_d[widx] = cdb_data_i[j];
        exc_d[widx]  = cdb_exc_i[j];
      end
    end
    if (rb_valid_i) begin
      head_d = rb_id_i + TW'(1);
      busy_d = busy_d & ~kill;
    end else if (disp_ready_o) begin
      for (int i = 0; i < DISP_W; i++) begin
        if (disp_valid_i[i]) begin
          dptr = head_q + TW'(i);
          busy_d[dptr[ID_W-1:0]] = 1'b1;
          done_d[dptr[ID_W-1:0]] = 1'b0;
          gen_d[dptr[ID_W-1:0]]  = dptr[ID_W];
          info_d[dptr[ID_W-1:0]] = disp_info_i[i];
          exc_d[dptr[ID_W-1:0]]  = '0;
        end
      end
      head_d = head_q + ndisp;
    end
    if (flush_i) begin
      head_d = '0;
      tail_d = '0;
      busy_d = '0;
      done_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      busy_q <= '0;
      done_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    gen_q  <= gen_d;
    info_q <= info_d;
    data_q <= data_d;
    exc_q  <= exc_d;
  end

  always_ff @(posedge clk) begin
    if (rst_n && !flush_i && rb_valid_i) begin
      assert (rb_off < cnt);
    end
  end

endmodule
